mem_stage: RTL and testbench

- MEM pipeline stage of the CPU, between the EX/MEM pipeline register and the control unit/WB.
- Performs the load/store for the instruction in EX. The scratch-pad memory (SPM) is accessed directly; every other address goes through a bus master FSM.
- Checks alignment and raises the misalignment exception.
- Holds the MEM/WB pipeline register (mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_exp_code, mem_out) that the control unit consumes. Drives mem_busy back to the control unit.

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_stage_bus_if.sv | 153 +++++++++++++++
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared constants for the MEM pipeline stage and its bus interface:
//   - memory operation codes carried from EX (NOP / LDW / STW)
//   - control-op NOP value used when the MEM/WB register is flushed
//   - bus interface FSM state encodings
//   - exception codes the stage produces or passes through
//   - default address-space selector for the scratch-pad memory
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam logic [1:0] MEM_OP_NOP = 2'd0;
    localparam logic [1:0] MEM_OP_LDW = 2'd1;
    localparam logic [1:0] MEM_OP_STW = 2'd2;

    localparam logic [1:0] CTRL_OP_NOP = 2'd0;

    localparam logic [1:0] BUS_IF_STATE_IDLE   = 2'd0;
    localparam logic [1:0] BUS_IF_STATE_REQ    = 2'd1;
    localparam logic [1:0] BUS_IF_STATE_ACCESS = 2'd2;
    localparam logic [1:0] BUS_IF_STATE_STALL  = 2'd3;

    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;

    // Top three address bits equal to this value select the scratch-pad.
    localparam logic [2:0] SPM_SEL_DEFAULT = 3'b011;

    // Word accesses need the two byte-offset bits of the address clear.
    function automatic logic addr_is_misaligned(input logic [1:0] byte_offset);
        return (byte_offset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// -----------------------------------------------------------------------------
// mem_stage_bus_if
// Routes one word access either to the scratch-pad memory (zero wait states)
// or to the external bus through a request/grant/strobe/ready handshake.
// Holds the bus FSM and the read buffer that keeps bus load data alive while
// the pipeline is stalled after the bus cycle has finished.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   stall, flush            pipeline hold / invalidate from the control unit
//   access                  a legal (aligned, exception-free) access is presented
//   rw                      1 = read (load), 0 = write (store)
//   addr, wr_data           word address and store data
//   rd_data                 load data for the current cycle (0 when none)
//   busy                    stage must be held because the bus is not done
//   spm_*                   scratch-pad memory interface
//   bus_*                   external bus master interface
// -----------------------------------------------------------------------------
module mem_stage_bus_if
    import mem_stage_pkg::*;
#(
    parameter int         WORD_ADDR_W = 30,
    parameter int         WORD_DATA_W = 32,
    parameter logic [2:0] SPM_SEL     = SPM_SEL_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   access,
    input  logic                   rw,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   busy,
    input  logic [WORD_DATA_W-1:0] spm_rd_data,
    output logic [WORD_ADDR_W-1:0] spm_addr,
    output logic                   spm_as_,
    output logic                   spm_rw,
    output logic [WORD_DATA_W-1:0] spm_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_,
    input  logic                   bus_grant_,
    output logic                   bus_req_,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD_DATA_W-1:0] bus_wr_data
);

    logic [1:0]             state;
    logic [WORD_DATA_W-1:0] rd_buf;
    logic                   is_spm;

    assign is_spm      = (addr[WORD_ADDR_W-1 -: 3] == SPM_SEL);
    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;

    // Combinational routing: SPM strobe, load data and busy for this cycle.
    always_comb begin
        rd_data = '0;
        busy    = 1'b0;
        spm_as_ = 1'b1;
        case (state)
            BUS_IF_STATE_IDLE: begin
                if (access && !flush) begin
                    if (is_spm) begin
                        spm_as_ = 1'b0;
                        if (rw) rd_data = spm_rd_data;
                    end else begin
                        // Bus access starts now; hold the pipeline from this cycle.
                        busy = 1'b1;
                    end
                end
            end
            BUS_IF_STATE_REQ: begin
                busy = 1'b1;
            end
            BUS_IF_STATE_ACCESS: begin
                if (!bus_rdy_) begin
                    if (rw) rd_data = bus_rd_data;
                end else begin
                    busy = 1'b1;
                end
            end
            BUS_IF_STATE_STALL: begin
                // Bus cycle already finished; replay the captured data.
                if (rw) rd_data = rd_buf;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Bus master FSM and read buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BUS_IF_STATE_IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
        end else begin
            case (state)
                BUS_IF_STATE_IDLE: begin
                    if (access && !flush && !is_spm) begin
                        state       <= BUS_IF_STATE_REQ;
                        bus_req_    <= 1'b0;
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                    end
                end
                BUS_IF_STATE_REQ: begin
                    if (flush) begin
                        // Nothing reached the bus yet, so the request can be withdrawn.
                        state       <= BUS_IF_STATE_IDLE;
                        bus_req_    <= 1'b1;
                        bus_rw      <= 1'b1;
                        bus_addr    <= '0;
                        bus_wr_data <= '0;
                    end else if (!bus_grant_) begin
                        state   <= BUS_IF_STATE_ACCESS;
                        bus_as_ <= 1'b0;
                    end
                end
                BUS_IF_STATE_ACCESS: begin
                    // Strobe is a single-cycle pulse; the cycle itself cannot be
                    // abandoned once started, even on flush.
                    bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        bus_req_    <= 1'b1;
                        bus_rw      <= 1'b1;
                        bus_addr    <= '0;
                        bus_wr_data <= '0;
                        rd_buf      <= bus_rd_data;
                        state       <= stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                    end
                end
                BUS_IF_STATE_STALL: begin
                    if (!stall) state <= BUS_IF_STATE_IDLE;
                end
                default: begin
                    state <= BUS_IF_STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage: performs the load/store of the instruction leaving EX,
// checks word alignment, and holds the MEM/WB pipeline register.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   stall, flush               hold / invalidate from the control unit
//   ex_*                       EX/MEM register contents (ex_out = address/result)
//   spm_*                      scratch-pad memory interface
//   bus_*                      external bus master interface
//   mem_busy                   stage is waiting on the bus
//   fwd_data                   combinational stage result forwarded to ID
//   mem_*                      MEM/WB register consumed by the control unit/WB
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int         WORD_ADDR_W = 30,
    parameter int         WORD_DATA_W = 32,
    parameter logic [2:0] SPM_SEL     = SPM_SEL_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   ex_en,
    input  logic [WORD_ADDR_W-1:0] ex_pc,
    input  logic                   ex_br_flag,
    input  logic [1:0]             ex_mem_op,
    input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    input  logic [1:0]             ex_ctrl_op,
    input  logic [4:0]             ex_dst_addr,
    input  logic                   ex_gpr_we_,
    input  logic [2:0]             ex_exp_code,
    input  logic [WORD_DATA_W-1:0] ex_out,
    input  logic [WORD_DATA_W-1:0] spm_rd_data,
    output logic [WORD_ADDR_W-1:0] spm_addr,
    output logic                   spm_as_,
    output logic                   spm_rw,
    output logic [WORD_DATA_W-1:0] spm_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_,
    input  logic                   bus_grant_,
    output logic                   bus_req_,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    output logic                   mem_busy,
    output logic [WORD_DATA_W-1:0] fwd_data,
    output logic                   mem_en,
    output logic [WORD_ADDR_W-1:0] mem_pc,
    output logic                   mem_br_flag,
    output logic [1:0]             mem_ctrl_op,
    output logic [4:0]             mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic [2:0]             mem_exp_code,
    output logic [WORD_DATA_W-1:0] mem_out
);

    logic                   mem_request;
    logic                   miss_align;
    logic                   access;
    logic                   is_load;
    logic                   rw;
    logic [2:0]             exp_code;
    logic                   gpr_we_;
    logic [WORD_DATA_W-1:0] rd_data;

    // Only a valid, exception-free memory instruction is checked for alignment;
    // an upstream exception takes priority and is passed through untouched.
    assign mem_request = ex_en && (ex_mem_op != MEM_OP_NOP) && (ex_exp_code == ISA_EXP_NO_EXP);
    assign miss_align  = mem_request && addr_is_misaligned(ex_out[1:0]);
    assign access      = mem_request && !miss_align;
    assign rw          = (ex_mem_op == MEM_OP_LDW);
    assign is_load     = access && rw;

    assign exp_code = miss_align ? ISA_EXP_MISS_ALIGN : ex_exp_code;
    assign gpr_we_  = miss_align ? 1'b1 : ex_gpr_we_;
    assign fwd_data = is_load ? rd_data : ex_out;

    mem_stage_bus_if #(
        .WORD_ADDR_W (WORD_ADDR_W),
        .WORD_DATA_W (WORD_DATA_W),
        .SPM_SEL     (SPM_SEL)
    ) u_bus_if (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .access      (access),
        .rw          (rw),
        .addr        (ex_out[WORD_ADDR_W+1:2]),
        .wr_data     (ex_mem_wr_data),
        .rd_data     (rd_data),
        .busy        (mem_busy),
        .spm_rd_data (spm_rd_data),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_),
        .bus_grant_  (bus_grant_),
        .bus_req_    (bus_req_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data)
    );

    // MEM/WB pipeline register boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en       <= 1'b0;
            mem_pc       <= '0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= CTRL_OP_NOP;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= ISA_EXP_NO_EXP;
            mem_out      <= '0;
        end else if (!stall) begin
            if (flush) begin
                // Only the fields that could cause side effects are cleared.
                mem_en       <= 1'b0;
                mem_ctrl_op  <= CTRL_OP_NOP;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= ISA_EXP_NO_EXP;
            end else begin
                mem_en       <= ex_en;
                mem_pc       <= ex_pc;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= gpr_we_;
                mem_exp_code <= exp_code;
                mem_out      <= fwd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        ex_en;
    logic [29:0] ex_pc;
    logic        ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;
    logic [31:0] spm_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic        bus_grant_;
    logic        bus_req_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic        mem_busy;
    logic [31:0] fwd_data;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int tests_run = 0;
    int tests_failed = 0;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .ex_en          (ex_en),
        .ex_pc          (ex_pc),
        .ex_br_flag     (ex_br_flag),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_ctrl_op     (ex_ctrl_op),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out),
        .spm_rd_data    (spm_rd_data),
        .spm_addr       (spm_addr),
        .spm_as_        (spm_as_),
        .spm_rw         (spm_rw),
        .spm_wr_data    (spm_wr_data),
        .bus_rd_data    (bus_rd_data),
        .bus_rdy_       (bus_rdy_),
        .bus_grant_     (bus_grant_),
        .bus_req_       (bus_req_),
        .bus_as_        (bus_as_),
        .bus_rw         (bus_rw),
        .bus_addr       (bus_addr),
        .bus_wr_data    (bus_wr_data),
        .mem_busy       (mem_busy),
        .fwd_data       (fwd_data),
        .mem_en         (mem_en),
        .mem_pc         (mem_pc),
        .mem_br_flag    (mem_br_flag),
        .mem_ctrl_op    (mem_ctrl_op),
        .mem_dst_addr   (mem_dst_addr),
        .mem_gpr_we_    (mem_gpr_we_),
        .mem_exp_code   (mem_exp_code),
        .mem_out        (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic en, input logic [29:0] pc, input logic [1:0] op,
                          input logic [31:0] wdata, input logic [4:0] dst, input logic we_,
                          input logic [2:0] exp, input logic [31:0] out);
        ex_en          = en;
        ex_pc          = pc;
        ex_br_flag     = 1'b0;
        ex_mem_op      = op;
        ex_mem_wr_data = wdata;
        ex_ctrl_op     = 2'd0;
        ex_dst_addr    = dst;
        ex_gpr_we_     = we_;
        ex_exp_code    = exp;
        ex_out         = out;
    endtask

    task automatic set_nop();
        set_ex(1'b0, 30'h0, MEM_OP_NOP, 32'h0, 5'd0, 1'b1, ISA_EXP_NO_EXP, 32'h0);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        spm_rd_data = 32'h0;
        bus_rd_data = 32'h0;
        bus_rdy_    = 1'b1;
        bus_grant_  = 1'b1;
        set_nop();

        // Reset state
        #1 reset = 1'b0;
        #2;
        check("rst_mem_en",    {31'b0, mem_en}, 32'h0);
        check("rst_gpr_we",    {31'b0, mem_gpr_we_}, 32'h1);
        check("rst_exp",       {29'b0, mem_exp_code}, 32'h0);
        check("rst_bus_req",   {31'b0, bus_req_}, 32'h1);
        check("rst_bus_as",    {31'b0, bus_as_}, 32'h1);
        check("rst_bus_rw",    {31'b0, bus_rw}, 32'h1);
        check("rst_bus_addr",  {2'b0, bus_addr}, 32'h0);
        check("rst_state",     {30'b0, dut.u_bus_if.state}, {30'b0, BUS_IF_STATE_IDLE});
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // 1: SPM load, zero wait states
        set_ex(1'b1, 30'h100, MEM_OP_LDW, 32'h0, 5'd5, 1'b0, ISA_EXP_NO_EXP, 32'h6000_0010);
        spm_rd_data = 32'hDEAD_BEEF;
        #1;
        check("spm_ld_as",     {31'b0, spm_as_}, 32'h0);
        check("spm_ld_addr",   {2'b0, spm_addr}, 32'h1800_0004);
        check("spm_ld_rw",     {31'b0, spm_rw}, 32'h1);
        check("spm_ld_busy",   {31'b0, mem_busy}, 32'h0);
        check("spm_ld_fwd",    fwd_data, 32'hDEAD_BEEF);
        check("spm_ld_breq",   {31'b0, bus_req_}, 32'h1);
        tick();
        check("spm_ld_out",    mem_out, 32'hDEAD_BEEF);
        check("spm_ld_en",     {31'b0, mem_en}, 32'h1);
        check("spm_ld_pc",     {2'b0, mem_pc}, 32'h100);
        check("spm_ld_dst",    {27'b0, mem_dst_addr}, 32'h5);
        check("spm_ld_we",     {31'b0, mem_gpr_we_}, 32'h0);

        // 1b: SPM store, result is the address
        set_ex(1'b1, 30'h101, MEM_OP_STW, 32'h0000_CAFE, 5'd0, 1'b1, ISA_EXP_NO_EXP, 32'h6000_0020);
        #1;
        check("spm_st_as",     {31'b0, spm_as_}, 32'h0);
        check("spm_st_rw",     {31'b0, spm_rw}, 32'h0);
        check("spm_st_wdata",  spm_wr_data, 32'h0000_CAFE);
        check("spm_st_fwd",    fwd_data, 32'h6000_0020);
        tick();
        check("spm_st_out",    mem_out, 32'h6000_0020);

        // 2: bus store, grant after 2 cycles, ready after 2 access cycles
        set_ex(1'b1, 30'h104, MEM_OP_STW, 32'h1234_5678, 5'd0, 1'b1, ISA_EXP_NO_EXP, 32'h0000_0100);
        #1;
        check("bst_busy_idle", {31'b0, mem_busy}, 32'h1);
        check("bst_spm_as",    {31'b0, spm_as_}, 32'h1);
        tick();
        check("bst_req",       {31'b0, bus_req_}, 32'h0);
        check("bst_as_req",    {31'b0, bus_as_}, 32'h1);
        check("bst_busy_req",  {31'b0, mem_busy}, 32'h1);
        tick();
        check("bst_req2",      {31'b0, bus_req_}, 32'h0);
        check("bst_as_req2",   {31'b0, bus_as_}, 32'h1);
        bus_grant_ = 1'b0;
        tick();
        bus_grant_ = 1'b1;
        check("bst_as_low",    {31'b0, bus_as_}, 32'h0);
        check("bst_addr",      {2'b0, bus_addr}, 32'h40);
        check("bst_rw",        {31'b0, bus_rw}, 32'h0);
        check("bst_wdata",     bus_wr_data, 32'h1234_5678);
        check("bst_busy_acc",  {31'b0, mem_busy}, 32'h1);
        tick();
        check("bst_as_pulse",  {31'b0, bus_as_}, 32'h1);
        check("bst_req_held",  {31'b0, bus_req_}, 32'h0);
        check("bst_busy_wait", {31'b0, mem_busy}, 32'h1);
        bus_rdy_ = 1'b0;
        #1;
        check("bst_busy_rdy",  {31'b0, mem_busy}, 32'h0);
        tick();
        bus_rdy_ = 1'b1;
        set_nop();
        check("bst_req_rel",   {31'b0, bus_req_}, 32'h1);
        check("bst_state",     {30'b0, dut.u_bus_if.state}, {30'b0, BUS_IF_STATE_IDLE});
        check("bst_out",       mem_out, 32'h0000_0100);
        tick();

        // 3: misaligned load
        set_ex(1'b1, 30'h108, MEM_OP_LDW, 32'h0, 5'd7, 1'b0, ISA_EXP_NO_EXP, 32'h0000_0102);
        #1;
        check("mis_spm_as",    {31'b0, spm_as_}, 32'h1);
        check("mis_busy",      {31'b0, mem_busy}, 32'h0);
        tick();
        check("mis_req",       {31'b0, bus_req_}, 32'h1);
        check("mis_exp",       {29'b0, mem_exp_code}, 32'h4);
        check("mis_we",        {31'b0, mem_gpr_we_}, 32'h1);

        // 3b: upstream exception passes through, SPM access suppressed
        set_ex(1'b1, 30'h10C, MEM_OP_LDW, 32'h0, 5'd7, 1'b0, 3'd2, 32'h6000_0000);
        #1;
        check("upx_spm_as",    {31'b0, spm_as_}, 32'h1);
        tick();
        check("upx_exp",       {29'b0, mem_exp_code}, 32'h2);
        check("upx_we",        {31'b0, mem_gpr_we_}, 32'h0);
        check("upx_out",       mem_out, 32'h6000_0000);

        // 4: bus load completing under stall
        set_ex(1'b1, 30'h110, MEM_OP_LDW, 32'h0, 5'd9, 1'b0, ISA_EXP_NO_EXP, 32'h0000_0200);
        stall = 1'b1;
        bus_rd_data = 32'hA5A5_0001;
        tick();
        check("bld_addr",      {2'b0, bus_addr}, 32'h80);
        check("bld_rw",        {31'b0, bus_rw}, 32'h1);
        bus_grant_ = 1'b0;
        tick();
        bus_grant_ = 1'b1;
        bus_rdy_ = 1'b0;
        #1;
        check("bld_busy_rdy",  {31'b0, mem_busy}, 32'h0);
        check("bld_fwd_rdy",   fwd_data, 32'hA5A5_0001);
        tick();
        bus_rdy_ = 1'b1;
        bus_rd_data = 32'h0;
        #1;
        check("bld_state_stl", {30'b0, dut.u_bus_if.state}, {30'b0, BUS_IF_STATE_STALL});
        check("bld_req_rel",   {31'b0, bus_req_}, 32'h1);
        check("bld_busy_stl",  {31'b0, mem_busy}, 32'h0);
        check("bld_fwd_buf",   fwd_data, 32'hA5A5_0001);
        check("bld_out_held",  mem_out, 32'h6000_0000);
        tick();
        check("bld_state_stl2", {30'b0, dut.u_bus_if.state}, {30'b0, BUS_IF_STATE_STALL});
        stall = 1'b0;
        tick();
        set_nop();
        check("bld_out",       mem_out, 32'hA5A5_0001);
        check("bld_dst",       {27'b0, mem_dst_addr}, 32'h9);
        check("bld_state_idl", {30'b0, dut.u_bus_if.state}, {30'b0, BUS_IF_STATE_IDLE});
        tick();

        // 5: flush while waiting for grant
        set_ex(1'b1, 30'h114, MEM_OP_LDW, 32'h0, 5'd3, 1'b0, ISA_EXP_NO_EXP, 32'h0000_0300);
        tick();
        check("fl_req",        {31'b0, bus_req_}, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_nop();
        check("fl_req_rel",    {31'b0, bus_req_}, 32'h1);
        check("fl_state",      {30'b0, dut.u_bus_if.state}, {30'b0, BUS_IF_STATE_IDLE});
        check("fl_en",         {31'b0, mem_en}, 32'h0);
        check("fl_we",         {31'b0, mem_gpr_we_}, 32'h1);
        check("fl_pc_held",    {2'b0, mem_pc}, 32'h114);
        tick();

        // 6: asynchronous reset during the bus access
        set_ex(1'b1, 30'h118, MEM_OP_STW, 32'h5555_AAAA, 5'd0, 1'b1, ISA_EXP_NO_EXP, 32'h0000_0400);
        tick();
        bus_grant_ = 1'b0;
        tick();
        bus_grant_ = 1'b1;
        check("rsa_state_acc", {30'b0, dut.u_bus_if.state}, {30'b0, BUS_IF_STATE_ACCESS});
        check("rsa_req",       {31'b0, bus_req_}, 32'h0);
        check("rsa_out_pre",   mem_out, 32'h0000_0400);
        #1;
        set_nop();
        reset = 1'b0;
        #1;
        check("rsa_req_rel",   {31'b0, bus_req_}, 32'h1);
        check("rsa_as",        {31'b0, bus_as_}, 32'h1);
        check("rsa_addr",      {2'b0, bus_addr}, 32'h0);
        check("rsa_state",     {30'b0, dut.u_bus_if.state}, {30'b0, BUS_IF_STATE_IDLE});
        check("rsa_mem_out",   mem_out, 32'h0);
        check("rsa_mem_en",    {31'b0, mem_en}, 32'h0);
        check("rsa_busy",      {31'b0, mem_busy}, 32'h0);
        #1 reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
